mem_arbiter: RTL and testbench

Two-port to one-port memory-access arbiter for the single-cycle/multicycle MIPS datapath. It is the merge-side counterpart of the write-enable decoder: instruction fetch (port 0) and load/store (port 1) requests are arbitrated round-robin onto one shared memory port. The arbiter holds the memory request until the memory acknowledges, then returns the read data and a one-cycle `ready` pulse to the granted port only.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/rr_pick2.sv | 20 ++
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

  localparam int ARB_AW_DEF = 32;
  localparam int ARB_DW_DEF = 32;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone request wins, a tie goes to the port that was not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt
);

  always_comb begin
    gnt_valid = |req;
    gnt       = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction-fetch (port 0) and load/store (port 1) requests onto one memory port,
// holding the latched request until mem_ready and returning a one-cycle ready to the granted port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = ARB_AW_DEF,
  parameter int DW = ARB_DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_req,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t state, state_nxt;
  logic       grant, last_grant;
  logic       pick_valid, pick;
  logic       take, done;

  rr_pick2 u_pick (
    .req       ({m1_req, m0_req}),
    .last      (last_grant),
    .gnt_valid (pick_valid),
    .gnt       (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Requests are only looked at in IDLE and mem_ready only in BUSY; RESP is a fixed one-cycle gap.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        take = pick_valid;
        if (pick_valid) state_nxt = BUSY;
      end
      BUSY: begin
        done = mem_ready;
        if (mem_ready) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else if (take) begin
      mem_req   <= 1'b1;
      grant     <= pick;
      mem_write <= pick ? m1_write : m0_write;
      mem_addr  <= pick ? m1_addr  : m0_addr;
      mem_wdata <= pick ? m1_wdata : m0_wdata;
    end else if (done) begin
      mem_req    <= 1'b0;
      last_grant <= grant;
    end
  end

  // Completion side: ready is a single-cycle pulse, rdata holds its last captured read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ready <= done && !grant;
      m1_ready <= done && grant;
      if (done && !mem_write && !grant) m0_rdata <= mem_rdata;
      if (done && !mem_write && grant)  m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level model with a behavioural memory.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req, m0_write, m1_req, m1_write;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_wdata;
  logic          m0_ready, m1_ready, mem_req, mem_write;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  logic        p_req[2];
  logic        p_wr[2];
  logic [31:0] p_addr[2];
  logic [31:0] p_wdata[2];

  assign m0_req = p_req[0];  assign m0_write = p_wr[0];
  assign m0_addr = p_addr[0]; assign m0_wdata = p_wdata[0];
  assign m1_req = p_req[1];  assign m1_write = p_wr[1];
  assign m1_addr = p_addr[1]; assign m1_wdata = p_wdata[1];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Transaction model: 0 = free, 1 = access in flight for port mp, 2 = completion reported to mp.
  int          ph, mp, mlast;
  logic        mwrite;
  logic [31:0] maddr, mwdata;
  logic [31:0] erd[2];
  logic [31:0] mem [logic [31:0]];

  int in_txn, cnt, lat, lat_fix, spur_mode, toggle_on, rand_on, reqcyc;
  int auto_rereq[2], issued[2], served[2], others_done[2];
  int order[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic model_reset();
    ph = 0; mp = 0; mlast = 1;
    erd[0] = '0; erd[1] = '0;
  endtask

  task automatic model_edge();
    if (reset) model_reset();
    else begin
      case (ph)
        0: if (p_req[0] || p_req[1]) begin
             if (p_req[0] && p_req[1]) mp = 1 - mlast;
             else                      mp = p_req[0] ? 0 : 1;
             mwrite = p_wr[mp]; maddr = p_addr[mp]; mwdata = p_wdata[mp];
             ph = 1;
           end
        1: if (mem_ready) begin
             if (mwrite) mem[maddr] = mwdata;
             else        erd[mp] = memrd(maddr);
             mlast = mp;
             ph = 2;
           end
        default: ph = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("mem_req", 32'(mem_req), 32'(ph == 1));
    if (ph == 1) begin
      chk("mem_write", 32'(mem_write), 32'(mwrite));
      chk("mem_addr", mem_addr, maddr);
      chk("mem_wdata", mem_wdata, mwdata);
    end
    chk("m0_ready", 32'(m0_ready), 32'(ph == 2 && mp == 0));
    chk("m1_ready", 32'(m1_ready), 32'(ph == 2 && mp == 1));
    chk("m0_rdata", m0_rdata, erd[0]);
    chk("m1_rdata", m1_rdata, erd[1]);
  endtask

  task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    p_req[i] = 1'b1; p_wr[i] = w; p_addr[i] = a; p_wdata[i] = d;
    issued[i]++;
  endtask

  task automatic issue_rand(input int i);
    issue(i, 1'($urandom_range(0, 1)), 32'h1000 | (32'($urandom_range(0, 7)) << 2), $urandom);
  endtask

  task automatic ports_update();
    logic r[2];
    r[0] = m0_ready; r[1] = m1_ready;
    for (int i = 0; i < 2; i++) begin
      if (r[i]) begin
        served[i]++;
        order.push_back(i);
        chk($sformatf("wait_bound%0d", i), 32'(others_done[i] > 1), 32'd0);
        others_done[i] = 0;
        if (p_req[1-i]) others_done[1-i]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (r[i]) begin
        p_req[i] = 1'b0;
        if (auto_rereq[i] != 0) issue_rand(i);
      end
      if (rand_on != 0 && !p_req[i] && $urandom_range(0, 1) == 1) issue_rand(i);
    end
  endtask

  task automatic respond();
    if (reset) begin
      in_txn = 0; mem_ready = 1'b0;
    end else if (mem_req) begin
      if (in_txn == 0) begin
        in_txn = 1; cnt = 0;
        lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      end
      mem_ready = (cnt == lat);
      mem_rdata = memrd(mem_addr);
      cnt++;
    end else begin
      in_txn = 0;
      mem_ready = (spur_mode == 1) || (spur_mode == 2 && $urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (mem_req) reqcyc++;
    ports_update();
    if (toggle_on != 0 && ph == 1) begin
      p_addr[mp] = p_addr[mp] ^ 32'h0000_0F00;
      p_wdata[mp] = ~p_wdata[mp];
    end
    respond();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic apply_reset();
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    model_reset();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    others_done[0] = 0; others_done[1] = 0;
    in_txn = 0;
    run(2);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      p_req[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
      auto_rereq[i] = 0; issued[i] = 0; served[i] = 0; others_done[i] = 0;
    end
    lat_fix = 0; spur_mode = 0; toggle_on = 0; rand_on = 0; in_txn = 0; cnt = 0; lat = 0;
    mem[32'h40] = 32'h1234_5678;
    model_reset();
    #2;
    apply_reset();

    // single read on port 0
    order.delete(); reqcyc = 0;
    issue(0, 1'b0, 32'h40, 32'h0);
    run(8);
    chk("t1_count", 32'(order.size()), 32'd1);
    if (order.size() > 0) chk("t1_port", 32'(order[0]), 32'd0);
    chk("t1_req_cycles", 32'(reqcyc), 32'd1);
    chk("t1_rdata", m0_rdata, 32'h1234_5678);

    // simultaneous requests after reset
    apply_reset();
    order.delete();
    issue(0, 1'b0, 32'h100, 32'h0);
    issue(1, 1'b1, 32'h200, 32'hDEAD_BEEF);
    run(10);
    chk("t2_count", 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      chk("t2_first", 32'(order[0]), 32'd0);
      chk("t2_second", 32'(order[1]), 32'd1);
    end
    chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2_m1_rdata", m1_rdata, 32'd0);

    // continuous contention
    order.delete();
    auto_rereq[0] = 1; auto_rereq[1] = 1;
    issue_rand(0); issue_rand(1);
    for (int k = 0; k < 60 && order.size() < 6; k++) cycle();
    auto_rereq[0] = 0; auto_rereq[1] = 0;
    chk("t3_count", 32'(order.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < order.size(); k++)
      chk($sformatf("t3_order%0d", k), 32'(order[k]), 32'(k % 2));
    run(20);

    // long memory latency with port inputs toggling while busy
    lat_fix = 4; toggle_on = 1;
    issue(1, 1'b1, 32'h300, 32'hCAFE_F00D);
    run(10);
    toggle_on = 0; lat_fix = 0;
    issue(0, 1'b0, 32'h300, 32'h0);
    run(6);
    chk("t4_readback", m0_rdata, 32'hCAFE_F00D);

    // spurious mem_ready in IDLE and RESP
    order.delete(); spur_mode = 1;
    run(4);
    issue(0, 1'b0, 32'h40, 32'h0);
    run(8);
    spur_mode = 0;
    chk("t5_count", 32'(order.size()), 32'd1);

    // reset two cycles into a port 1 read
    apply_reset();
    order.delete(); lat_fix = 6;
    issue(1, 1'b0, 32'h80, 32'h0);
    run(2);
    #2;
    apply_reset();
    chk("t6_no_ready", 32'(order.size()), 32'd0);
    lat_fix = 0;
    issue(0, 1'b0, 32'h84, 32'h0);
    issue(1, 1'b0, 32'h88, 32'h0);
    run(10);
    chk("t6_count", 32'(order.size()), 32'd2);
    if (order.size() > 0) chk("t6_tie_port0", 32'(order[0]), 32'd0);

    // randomized traffic
    for (int i = 0; i < 2; i++) begin issued[i] = 0; served[i] = 0; end
    lat_fix = -1; spur_mode = 2; rand_on = 1;
    run(400);
    rand_on = 0; spur_mode = 0;
    run(40);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rand_served%0d", i), 32'(served[i]), 32'(issued[i]));
      chk($sformatf("rand_active%0d", i), 32'(served[i] > 10), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
